// File: rtl/seq_window_checker_pkg.sv
// Shared constants and types for the sequence-window checker.
package seq_window_checker_pkg;

    localparam int unsigned CH_MIN      = 1;
    localparam int unsigned CH_MAX      = 16;
    localparam int unsigned DLY_MAX_LIM = 31;
    localparam int unsigned CNT_W_MIN   = 8;
    localparam int unsigned CNT_W_MAX   = 32;

    typedef logic [CNT_W_MAX-1:0] cnt_t;

endpackage

// File: rtl/seq_window_lane.sv
// One channel of "a |-> ##[MIN_DLY:MAX_DLY] b": pending ages, pulses, counters.
module seq_window_lane
    import seq_window_checker_pkg::*;
#(
    parameter int unsigned MIN_DLY = 2,
    parameter int unsigned MAX_DLY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             pass_o,
    output logic             fail_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    // Bit i of the pending vector holds the attempt of age i+1.
    localparam int unsigned          LOW_BITS = (MIN_DLY == 0) ? 0 : MIN_DLY - 1;
    localparam logic [MAX_DLY-1:0]   ELIG     = ~MAX_DLY'((64'd1 << LOW_BITS) - 64'd1);
    localparam cnt_t                 SAT      = cnt_t'((64'd1 << CNT_W) - 64'd1);

    logic [MAX_DLY-1:0] pend_q, pend_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    logic               start;
    logic               imm;
    logic [MAX_DLY-1:0] survive;

    always_comb begin
        start   = a_i & en_i;
        imm     = (MIN_DLY == 0) && start && b_i;
        survive = pend_q & ~({MAX_DLY{b_i}} & ELIG);
        // Shift survivors up one age; the age-MAX slot drops off (passed or failed).
        pend_d  = MAX_DLY'({survive, start & ~imm});
        pass_d  = (b_i & (|(pend_q & ELIG))) | imm;
        fail_d  = pend_q[MAX_DLY-1] & ~b_i;

        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        sticky_d   = sticky_q | fail_d;
        if (pass_d && (pass_cnt_q != SAT[CNT_W-1:0])) pass_cnt_d = pass_cnt_q + CNT_W'(1);
        if (fail_d && (fail_cnt_q != SAT[CNT_W-1:0])) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        if (clr_i) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            sticky_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            sticky_q   <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            sticky_q   <= sticky_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign err_sticky_o = sticky_q;
    assign pass_cnt_o   = pass_cnt_q;
    assign fail_cnt_o   = fail_cnt_q;

endmodule

// File: rtl/seq_window_checker.sv
// Multi-channel window checker: CH independent seq_window_lane instances.
module seq_window_checker
    import seq_window_checker_pkg::*;
#(
    parameter int unsigned CH      = 1,
    parameter int unsigned MIN_DLY = 2,
    parameter int unsigned MAX_DLY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic [CH-1:0]       a,
    input  logic [CH-1:0]       b,
    output logic [CH-1:0]       pass_o,
    output logic [CH-1:0]       fail_o,
    output logic [CH-1:0]       err_sticky_o,
    output logic [CH*CNT_W-1:0] pass_cnt_o,
    output logic [CH*CNT_W-1:0] fail_cnt_o
);

    if ((CH < CH_MIN) || (CH > CH_MAX) || (MAX_DLY < 1) || (MAX_DLY > DLY_MAX_LIM) ||
        (MIN_DLY > MAX_DLY) || (CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX)) begin : g_param_err
        $fatal(1, "seq_window_checker: illegal parameter combination");
    end

    for (genvar g = 0; g < CH; g++) begin : g_lane
        seq_window_lane #(
            .MIN_DLY (MIN_DLY),
            .MAX_DLY (MAX_DLY),
            .CNT_W   (CNT_W)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .en_i         (en),
            .clr_i        (clr),
            .a_i          (a[g]),
            .b_i          (b[g]),
            .pass_o       (pass_o[g]),
            .fail_o       (fail_o[g]),
            .err_sticky_o (err_sticky_o[g]),
            .pass_cnt_o   (pass_cnt_o[g*CNT_W +: CNT_W]),
            .fail_cnt_o   (fail_cnt_o[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_seq_window_checker.sv
// Bench for seq_window_checker: three configurations against an attempt-list model.
module tb_seq_window_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, clr;
    logic a0, b0, a2, b2;
    logic [1:0] a1, b1;

    logic p0, f0, s0, p2, f2, s2;
    logic [7:0] pc0, fc0, pc2, fc2;
    logic [1:0] p1, f1, s1;
    logic [31:0] pc1, fc1;

    seq_window_checker #(.CH(1), .MIN_DLY(2), .MAX_DLY(2), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a0), .b(b0),
        .pass_o(p0), .fail_o(f0), .err_sticky_o(s0), .pass_cnt_o(pc0), .fail_cnt_o(fc0));

    seq_window_checker #(.CH(2), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a1), .b(b1),
        .pass_o(p1), .fail_o(f1), .err_sticky_o(s1), .pass_cnt_o(pc1), .fail_cnt_o(fc1));

    seq_window_checker #(.CH(1), .MIN_DLY(0), .MAX_DLY(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a2), .b(b2),
        .pass_o(p2), .fail_o(f2), .err_sticky_o(s2), .pass_cnt_o(pc2), .fail_cnt_o(fc2));

    typedef struct packed {
        logic [3:0]       p;
        logic [3:0]       f;
        logic [3:0]       s;
        logic [3:0][31:0] pc;
        logic [3:0][31:0] fc;
    } exp_t;

    typedef struct {
        logic [4:0] in;   // {rst, en, clr, a, b} for dut0
        logic [2:0] out;  // {pass, fail, sticky}
        int         pc;
        int         fc;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    // Model channels: 0 = dut0, 1/2 = dut1 ch0/ch1, 3 = dut2.
    int          mmin[4] = '{2, 1, 1, 0};
    int          mmax[4] = '{2, 3, 3, 1};
    int unsigned msat[4] = '{255, 65535, 65535, 255};
    int unsigned mpc[4];
    int unsigned mfc[4];
    bit          ms[4];
    int          att[4][$];
    int          tcur = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h (t=%0d)", nm, idx, act, exp, tcur);
        end
    endtask

    function automatic logic ain(int m);
        case (m)
            0: return a0;
            1: return a1[0];
            2: return a1[1];
            default: return a2;
        endcase
    endfunction

    function automatic logic bin(int m);
        case (m)
            0: return b0;
            1: return b1[0];
            2: return b1[1];
            default: return b2;
        endcase
    endfunction

    task automatic model_edge();
        exp_t e;
        int   q[$];
        int   age;
        bit   p, f;
        e = '0;
        for (int m = 0; m < 4; m++) begin
            p = 1'b0;
            f = 1'b0;
            if (rst) begin
                att[m].delete();
                mpc[m] = 0;
                mfc[m] = 0;
                ms[m]  = 1'b0;
            end else begin
                q.delete();
                for (int i = 0; i < att[m].size(); i++) begin
                    age = tcur - att[m][i];
                    if (bin(m) && age >= mmin[m]) p = 1'b1;
                    else if (age >= mmax[m])      f = 1'b1;
                    else                          q.push_back(att[m][i]);
                end
                att[m] = q;
                if (ain(m) && en) begin
                    if (mmin[m] == 0 && bin(m)) p = 1'b1;
                    else                        att[m].push_back(tcur);
                end
                if (clr) begin
                    mpc[m] = 0;
                    mfc[m] = 0;
                    ms[m]  = 1'b0;
                end else begin
                    if (p && mpc[m] < msat[m]) mpc[m]++;
                    if (f && mfc[m] < msat[m]) mfc[m]++;
                    ms[m] = ms[m] | f;
                end
            end
            e.p[m]  = p;
            e.f[m]  = f;
            e.s[m]  = ms[m];
            e.pc[m] = mpc[m];
            e.fc[m] = mfc[m];
        end
        tcur++;
        sb.push_back(e);
    endtask

    function automatic exp_t get_act();
        exp_t x;
        x.p     = {p2, p1, p0};
        x.f     = {f2, f1, f0};
        x.s     = {s2, s1, s0};
        x.pc[0] = 32'(pc0);
        x.pc[1] = 32'(pc1[15:0]);
        x.pc[2] = 32'(pc1[31:16]);
        x.pc[3] = 32'(pc2);
        x.fc[0] = 32'(fc0);
        x.fc[1] = 32'(fc1[15:0]);
        x.fc[2] = 32'(fc1[31:16]);
        x.fc[3] = 32'(fc2);
        return x;
    endfunction

    // Apply current inputs at one edge and compare every channel after it.
    task automatic step();
        exp_t e, x;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        x = get_act();
        for (int m = 0; m < 4; m++) begin
            chk("sb_pass",   m, 32'(x.p[m]), 32'(e.p[m]));
            chk("sb_fail",   m, 32'(x.f[m]), 32'(e.f[m]));
            chk("sb_sticky", m, 32'(x.s[m]), 32'(e.s[m]));
            chk("sb_pcnt",   m, x.pc[m], e.pc[m]);
            chk("sb_fcnt",   m, x.fc[m], e.fc[m]);
        end
    endtask

    task automatic add(input logic [4:0] in, input logic [2:0] out, input int pc, input int fc);
        vec_t v;
        v.in = in; v.out = out; v.pc = pc; v.fc = fc;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = 1'b1; clr = 1'b0;
        a0 = 1'b0; b0 = 1'b0; a1 = 2'b00; b1 = 2'b00; a2 = 1'b0; b2 = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);

        // dut0 (MIN=MAX=2, CNT_W=8) directed vectors
        add(5'b11000, 3'b000, 0, 0);  // reset
        add(5'b01010, 3'b000, 0, 0);  // a @ e0
        add(5'b01000, 3'b000, 0, 0);
        add(5'b01001, 3'b100, 1, 0);  // b @ e2 -> pass
        add(5'b01000, 3'b000, 1, 0);
        add(5'b01010, 3'b000, 1, 0);  // a @ e0
        add(5'b01001, 3'b000, 1, 0);  // b @ e1 too early
        add(5'b01000, 3'b011, 1, 1);  // fail @ e2
        add(5'b01001, 3'b001, 1, 1);  // b @ e3 too late
        add(5'b01000, 3'b001, 1, 1);
        add(5'b01100, 3'b000, 0, 0);  // clr
        add(5'b01010, 3'b000, 0, 0);  // a @ e0
        add(5'b11000, 3'b000, 0, 0);  // rst @ e1
        add(5'b01001, 3'b000, 0, 0);  // b @ e2 ignored
        add(5'b01000, 3'b000, 0, 0);
        add(5'b01000, 3'b000, 0, 0);
        add(5'b01010, 3'b000, 0, 0);  // a held e0..e3, b=0
        add(5'b01010, 3'b000, 0, 0);
        add(5'b01010, 3'b011, 0, 1);
        add(5'b01010, 3'b011, 0, 2);
        add(5'b01000, 3'b011, 0, 3);
        add(5'b01000, 3'b011, 0, 4);
        add(5'b01000, 3'b001, 0, 4);
        add(5'b01010, 3'b001, 0, 4);
        add(5'b01000, 3'b001, 0, 4);
        add(5'b01100, 3'b010, 0, 0);  // clr beats same-edge fail
        add(5'b01000, 3'b000, 0, 0);
        add(5'b00010, 3'b000, 0, 0);  // en=0 blocks start
        add(5'b00000, 3'b000, 0, 0);
        add(5'b00000, 3'b000, 0, 0);
        add(5'b01010, 3'b000, 0, 0);  // start, then en=0 while pending
        add(5'b00000, 3'b000, 0, 0);
        add(5'b00000, 3'b011, 0, 1);
        add(5'b00000, 3'b001, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            idle_inputs();
            {rst, en, clr, a0, b0} = tbl[i].in;
            step();
            chk("tbl_pass",   i, 32'(p0),  32'(tbl[i].out[2]));
            chk("tbl_fail",   i, 32'(f0),  32'(tbl[i].out[1]));
            chk("tbl_sticky", i, 32'(s0),  32'(tbl[i].out[0]));
            chk("tbl_pcnt",   i, 32'(pc0), tbl[i].pc);
            chk("tbl_fcnt",   i, 32'(fc0), tbl[i].fc);
        end

        // dut1 (MIN=1, MAX=3): two overlapping attempts satisfied by one b
        idle_inputs(); rst = 1'b1; step();
        idle_inputs(); a1 = 2'b01; step();
        step();
        a1 = 2'b00; step();
        b1 = 2'b01; step();
        chk("ovl_pass", 0, 32'(p1), 32'h1);
        chk("ovl_fail", 0, 32'(f1), 32'h0);
        b1 = 2'b00; step();
        chk("ovl_pulse_end", 0, 32'(p1), 32'h0);
        chk("ovl_pcnt0", 0, pc1[15:0], 32'h1);
        chk("ovl_ch1_pcnt", 1, pc1[31:16], 32'h0);
        chk("ovl_fcnt", 0, fc1, 32'h0);
        chk("ovl_sticky", 0, 32'(s1), 32'h0);
        repeat (3) step();
        chk("ovl_no_fail", 0, 32'(f1), 32'h0);

        // dut2 (MIN=0): same-edge a and b pass immediately and never pend
        idle_inputs(); a2 = 1'b1; b2 = 1'b1; step();
        chk("imm_pass", 0, 32'(p2), 32'h1);
        idle_inputs(); step();
        chk("imm_fail", 0, 32'(f2), 32'h0);
        chk("imm_pcnt", 0, 32'(pc2), 32'h1);
        step();
        chk("imm_fail2", 0, 32'(f2), 32'h0);

        // dut0 fail counter saturation at 255, then clr
        idle_inputs(); rst = 1'b1; step();
        idle_inputs(); a0 = 1'b1;
        repeat (302) step();
        chk("sat_fcnt", 0, 32'(fc0), 32'd255);
        step();
        chk("sat_hold", 0, 32'(fc0), 32'd255);
        clr = 1'b1; step();
        chk("sat_clr", 0, 32'(fc0), 32'd0);
        chk("sat_clr_sticky", 0, 32'(s0), 32'd0);
        idle_inputs(); repeat (4) step();

        // Random traffic, checked against the model only
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            clr = ($urandom_range(0, 29) == 0);
            en  = ($urandom_range(0, 9) != 0);
            a0 = 1'($urandom); b0 = 1'($urandom);
            a1 = 2'($urandom); b1 = 2'($urandom);
            a2 = 1'($urandom); b2 = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
